spike_time_encoder: RTL and testbench
=====================================

Name: spike_time_encoder

Overview:
- Transmit side of the spike interface: converts per-line spike times into temporally coded spike pulses on a NUM_INPUTS-wide bus, one gamma cycle per accepted vector.
- Sits upstream of the WTA column and drives its input_spikes bus.
- Each accepted vector produces one gamma cycle of GAMMA_CYCLE_WIDTH clocks. Line i pulses high for PULSE_WIDTH clocks starting at its encoded time.

Parameters:
- GAMMA_CYCLE_WIDTH, 16: clocks per gamma cycle; must be ≥2.
- PULSE_WIDTH, 8: spike pulse length in clocks; range 1..GAMMA_CYCLE_WIDTH.
- NUM_INPUTS, 16: number of spike lines.
- TIME_W, $clog2(GAMMA_CYCLE_WIDTH): width of each time field (localparam, derived).

Ports:
- aclk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  spike-time vector available.
- in_ready  output  1  encoder can accept a vector this cycle.
- in_times  input  NUM_INPUTS*TIME_W  packed times; line i occupies bits [i*TIME_W +: TIME_W].
- in_mask  input  NUM_INPUTS  1 = line i spikes this gamma; 0 = silent.
- output_spikes  output  NUM_INPUTS  registered spike bus.
- gamma_start  output  1  one-clock pulse on the first clock of each gamma cycle.
- busy  output  1  gamma cycle in progress.

Behaviour:
- Clock and reset:
  - One clock, aclk. Reset is synchronous and active-low on rst_n.
  - On any edge with rst_n=0: state=IDLE, counter=0, stored times/mask cleared, output_spikes=0, gamma_start=0, busy=0.
  - After reset, in_ready=1.
  - Reset asserted mid-gamma aborts the gamma; all spikes go low on that same edge.
- State machine:
  - IDLE:
    - in_ready=1.
    - Handshake (in_valid & in_ready) latches in_times and in_mask, sets counter=0, and moves to RUN.
  - RUN:
    - Counter increments each clock, 0..GAMMA_CYCLE_WIDTH-1.
    - At counter==GAMMA_CYCLE_WIDTH-1, in_ready=1.
    - If the handshake occurs there: relatch, counter wraps to 0, stay in RUN (back-to-back, no bubble).
    - Otherwise go to IDLE.
- in_ready is combinational from state/counter only, never from in_valid. in_valid without in_ready is ignored; no data is captured.
- Latency:
  - Handshake at edge k → counter=0 during cycle k+1.
  - gamma_start=1 and busy=1 during cycle k+1.
- Output rule: output_spikes[i]=1 during the cycle with counter value c iff all of the following hold:
  - mask_i=1;
  - t_i ≤ c;
  - c < t_i+PULSE_WIDTH;
  - state is RUN.
- The comparison is computed from next-state values and registered, so the spike appears exactly in the cycle where counter==t_i.
- Pulses are clipped at the gamma end and never carry into the next gamma. If t_i ≥ GAMMA_CYCLE_WIDTH (non-power-of-2 gamma), line i is silent.
- Back-to-back gammas where line i ends one gamma high and starts the next at t=0: the line stays continuously high. This is legal; consumers delimit gammas with gamma_start.
- busy=1 in RUN. busy falls the cycle after the last gamma clock when no new vector is accepted. output_spikes=0 in IDLE.
- Arithmetic: t_i+PULSE_WIDTH is evaluated at TIME_W+1 bits or wider so there is no overflow wrap.

Optional Feature:
- Macro: SPIKE_ENC_INVERT_EN.
- Defined: effective time = (GAMMA_CYCLE_WIDTH-1) - in_times field, so larger value → earlier spike (intensity coding). Fields above GAMMA_CYCLE_WIDTH-1 are silent.
- Undefined: effective time = in_times field directly.
- Handshake, clipping and timing are identical in both builds.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 clocks with in_valid=1 → output_spikes=0, busy=0, in_ready=1, no gamma_start. Release with in_valid=0 → outputs stay 0.
- Single vector: all lines mask=1, line i time=i, accepted at edge k.
  - gamma_start high in cycle k+1.
  - Line 0 high cycles k+1..k+8.
  - Line 15 high cycles k+16 only (clipped to 1 clock).
  - busy low at k+17.
- Mask and silence: mask=16'h00FF with times all 3 → lines 0–7 high at counter 3..10; lines 8–15 never high.
- Back-to-back:
  - in_valid held high with vectors A (all t=12) and B (all t=0).
  - Second handshake occurs at counter 15; B's gamma_start follows A's by exactly 16 clocks.
  - Lines stay high counter 12 of A through counter 7 of B.
- Mid-gamma reset: rst_n=0 at counter 5 with line 0 t=2 spiking → output_spikes=0 and busy=0 on that edge; next vector restarts at counter 0.
- SPIKE_ENC_INVERT_EN build: time field 15 → spike at counter 0; field 0 → spike at counter 15 (1 clock).

Source files
------------

// File: rtl/spike_time_encoder.sv
// Temporal spike encoder: each accepted spike-time vector becomes one gamma cycle
// of PULSE_WIDTH-clock pulses. Optional feature macro: SPIKE_ENC_INVERT_EN (intensity coding).
module spike_time_encoder #(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned PULSE_WIDTH       = 8,
    parameter int unsigned NUM_INPUTS        = 16,
    localparam int unsigned TIME_W           = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                         aclk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_INPUTS*TIME_W-1:0] in_times,
    input  logic [NUM_INPUTS-1:0]        in_mask,
    output logic [NUM_INPUTS-1:0]        output_spikes,
    output logic                         gamma_start,
    output logic                         busy
);

    localparam int unsigned SUM_W   = TIME_W + 1;
    localparam int unsigned TIMES_W = NUM_INPUTS * TIME_W;
    localparam logic [TIME_W-1:0] LAST_CNT = TIME_W'(GAMMA_CYCLE_WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_nxt;
    logic [TIME_W-1:0]       cnt_q, cnt_nxt;
    logic [TIMES_W-1:0]      times_q, times_nxt;
    logic [NUM_INPUTS-1:0]   mask_q, mask_nxt;
    logic [NUM_INPUTS-1:0]   spikes_nxt;
    logic                    gamma_start_nxt;
    logic                    busy_nxt;
    logic                    handshake;
    logic                    last_clk;

    // True when a line whose time field is 'field' is high at counter value 'c'.
    function automatic logic line_hot(input logic [TIME_W-1:0] field,
                                      input logic [TIME_W-1:0] c);
        logic [SUM_W-1:0] eff;
        logic             in_range;
`ifdef SPIKE_ENC_INVERT_EN
        in_range = (SUM_W'(field) <= SUM_W'(GAMMA_CYCLE_WIDTH - 1));
        eff      = SUM_W'(GAMMA_CYCLE_WIDTH - 1) - SUM_W'(field);
`else
        in_range = 1'b1;
        eff      = SUM_W'(field);
`endif
        // Counter never exceeds the last gamma clock, so pulses clip naturally.
        return in_range && (eff <= SUM_W'(c)) && (SUM_W'(c) < (eff + SUM_W'(PULSE_WIDTH)));
    endfunction

    assign last_clk  = (cnt_q == LAST_CNT);
    assign in_ready  = (state_q == IDLE) || ((state_q == RUN) && last_clk);
    assign handshake = in_valid && in_ready;

    // State register plus registered outputs.
    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            times_q       <= '0;
            mask_q        <= '0;
            output_spikes <= '0;
            gamma_start   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            cnt_q         <= cnt_nxt;
            times_q       <= times_nxt;
            mask_q        <= mask_nxt;
            output_spikes <= spikes_nxt;
            gamma_start   <= gamma_start_nxt;
            busy          <= busy_nxt;
        end
    end

    // Next-state logic; outputs are derived from next-state values so they line up after the register.
    always_comb begin
        state_nxt       = state_q;
        cnt_nxt         = cnt_q;
        times_nxt       = times_q;
        mask_nxt        = mask_q;
        spikes_nxt      = '0;
        gamma_start_nxt = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_nxt = '0;
                if (handshake) begin
                    state_nxt       = RUN;
                    times_nxt       = in_times;
                    mask_nxt        = in_mask;
                    gamma_start_nxt = 1'b1;
                end
            end
            RUN: begin
                if (last_clk) begin
                    cnt_nxt = '0;
                    if (handshake) begin
                        times_nxt       = in_times;
                        mask_nxt        = in_mask;
                        gamma_start_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_q + TIME_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt == RUN);

        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            spikes_nxt[i] = (state_nxt == RUN) && mask_nxt[i] &&
                            line_hot(times_nxt[i*TIME_W +: TIME_W], cnt_nxt);
        end
    end

endmodule

// File: tb/tb_spike_time_encoder.sv
// Scoreboard bench for spike_time_encoder: per-cycle expected outputs are queued on
// each handshake and a negedge monitor pops and compares them.
module tb_spike_time_encoder;

    localparam int unsigned G  = 16;
    localparam int unsigned PW = 8;
    localparam int unsigned N  = 16;
    localparam int unsigned TW = $clog2(G);

    typedef struct packed {
        logic [N-1:0] spk;
        logic         gs;
        logic         busy;
    } exp_t;

    logic              aclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*TW-1:0]   in_times = '0;
    logic [N-1:0]      in_mask = '0;
    logic [N-1:0]      output_spikes;
    logic              gamma_start;
    logic              busy;

    exp_t exp_q[$];
    logic model_ready = 1'b1;
    logic accepted = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    spike_time_encoder #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH(PW),
        .NUM_INPUTS(N)
    ) dut (
        .aclk(aclk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_times(in_times),
        .in_mask(in_mask),
        .output_spikes(output_spikes),
        .gamma_start(gamma_start),
        .busy(busy)
    );

    always #5 aclk = ~aclk;

    // Reference: which lines are high at counter value c for a given vector.
    function automatic logic [N-1:0] ref_spikes(input logic [N*TW-1:0] t,
                                                input logic [N-1:0] m, input int c);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            int  f;
            int  e;
            bit  ok;
            f  = int'(t[i*TW +: TW]);
            ok = 1'b1;
`ifdef SPIKE_ENC_INVERT_EN
            if (f > int'(G) - 1) ok = 1'b0;
            e = int'(G) - 1 - f;
`else
            e = f;
`endif
            r[i] = m[i] && ok && (e <= c) && (c < e + int'(PW));
        end
        return r;
    endfunction

    // One clock; the model observes the handshake on the same edge as the DUT.
    task automatic cycle();
        @(posedge aclk);
        accepted = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
        end else if (in_valid && model_ready) begin
            for (int c = 0; c < int'(G); c++) begin
                exp_t e;
                e.spk  = ref_spikes(in_times, in_mask, c);
                e.gs   = (c == 0);
                e.busy = 1'b1;
                exp_q.push_back(e);
            end
            accepted = 1'b1;
        end
        #1;
    endtask

    task automatic send(input logic [N*TW-1:0] t, input logic [N-1:0] m, input bit keep_valid);
        int n;
        in_times = t;
        in_mask  = m;
        in_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 40);
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout cyc=%0d got=no_handshake exp=handshake", cyc);
        end
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic logic [N*TW-1:0] all_times(input int v);
        logic [N*TW-1:0] r;
        for (int i = 0; i < int'(N); i++) r[i*TW +: TW] = TW'(v);
        return r;
    endfunction

    // Monitor: compares every cycle; an empty queue means the encoder must be idle.
    always @(negedge aclk) begin
        exp_t e;
        cyc++;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (output_spikes !== e.spk) begin
            failures++;
            $display("FAIL spikes cyc=%0d got=%h exp=%h", cyc, output_spikes, e.spk);
        end
        checks++;
        if (gamma_start !== e.gs) begin
            failures++;
            $display("FAIL gamma_start cyc=%0d got=%b exp=%b", cyc, gamma_start, e.gs);
        end
        checks++;
        if (busy !== e.busy) begin
            failures++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e.busy);
        end
        model_ready = (exp_q.size() == 0);
        checks++;
        if (in_ready !== model_ready) begin
            failures++;
            $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, model_ready);
        end
    end

    initial begin
        logic [N*TW-1:0] ramp;
        for (int i = 0; i < int'(N); i++) ramp[i*TW +: TW] = TW'(i);

        // Reset held with in_valid asserted must not start a gamma.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_mask  = '1;
        idle(3);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle(3);

        send(ramp, '1, 1'b0);
        idle(20);

        send(all_times(3), N'(16'h00FF), 1'b0);
        idle(18);

        // Back-to-back: B is offered while A runs and is taken at A's last clock.
        send(all_times(12), '1, 1'b1);
        send(all_times(0), '1, 1'b0);
        idle(20);

        // Mid-gamma reset at counter 5, then a fresh vector.
        send(all_times(2), N'(1), 1'b0);
        idle(5);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(2);
        send(all_times(2), N'(1), 1'b0);
        idle(18);

        // Extreme field values.
        send(all_times(int'(G) - 1), '1, 1'b0);
        send(all_times(0), '1, 1'b0);
        idle(18);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < int'(N); i++) in_times[i*TW +: TW] = TW'($urandom);
            in_mask = N'($urandom);
            rst_n   = ($urandom_range(0, 99) != 0);
            cycle();
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle(G + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
